// File: rtl/audio_soft_ramp_if.sv
// Sample stream between the audio core, the soft-ramp stage and the I2S transmitter.
// The master drives the strobe, the raw samples and the mute level. The slave (the ramp)
// returns the scaled pair and its status flags.
interface audio_soft_ramp_if #(
    parameter int unsigned DATA_W = 16
);
    logic              sample_stb;
    logic [DATA_W-1:0] in_l;
    logic [DATA_W-1:0] in_r;
    logic              mute;
    logic [DATA_W-1:0] out_l;
    logic [DATA_W-1:0] out_r;
    logic              out_valid;
    logic              muted;
    logic              ramping;

    modport master (
        output sample_stb,
        output in_l,
        output in_r,
        output mute,
        input  out_l,
        input  out_r,
        input  out_valid,
        input  muted,
        input  ramping
    );

    modport slave (
        input  sample_stb,
        input  in_l,
        input  in_r,
        input  mute,
        output out_l,
        output out_r,
        output out_valid,
        output muted,
        output ramping
    );
endinterface

// File: rtl/audio_soft_ramp.sv
// Click-free soft mute and start-up volume ramp placed ahead of the I2S transmitter.
// A stepped gain (GAIN_W fraction bits, unity = 2**GAIN_W) scales each stereo pair.
// The gain advances one LSB every STEP_SAMPLES accepted strobes while ramping.
// Datapath: capture (strobe edge) -> product register -> arithmetic shift slice.
// out_valid therefore appears exactly two cycles after sample_stb.
module audio_soft_ramp #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned GAIN_W       = 8,
    parameter int unsigned STEP_SAMPLES = 64
) (
    input logic              clk,
    input logic              reset_n,
    audio_soft_ramp_if.slave bus
);
    localparam int unsigned CNT_W  = (STEP_SAMPLES > 1) ? $clog2(STEP_SAMPLES) : 1;
    localparam int unsigned PROD_W = DATA_W + GAIN_W + 1;

    localparam logic [GAIN_W:0]  GAIN_UNITY = {1'b1, {GAIN_W{1'b0}}};
    localparam logic [GAIN_W:0]  GAIN_ONE   = {{GAIN_W{1'b0}}, 1'b1};
    localparam logic [GAIN_W:0]  GAIN_TOP   = GAIN_UNITY - GAIN_ONE;
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STEP_SAMPLES - 1);

    typedef enum logic [1:0] {
        StMuted,
        StRampUp,
        StUnity,
        StRampDown
    } state_e;

    // Control state
    state_e           state_q;
    logic [GAIN_W:0]  gain_q;
    logic [CNT_W-1:0] step_cnt_q;
    logic             muted_q;
    logic             ramping_q;
    logic             step_done;

    // Pipeline state
    logic                     cap_valid_q;
    logic        [DATA_W-1:0] cap_l_q;
    logic        [DATA_W-1:0] cap_r_q;
    logic        [GAIN_W:0]   cap_gain_q;
    logic        [PROD_W-1:0] mul_l;
    logic        [PROD_W-1:0] mul_r;
    logic        [PROD_W-1:0] gain_ext;
    logic                     prod_valid_q;
    logic        [PROD_W-1:0] prod_l_q;
    logic        [PROD_W-1:0] prod_r_q;
    logic                     unused_prod_bits;

    assign step_done = (step_cnt_q == CNT_LAST);

    // Gain FSM: advances only on strobe cycles; flags are registered decodes of the new state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StMuted;
            gain_q     <= '0;
            step_cnt_q <= '0;
            muted_q    <= 1'b1;
            ramping_q  <= 1'b0;
        end else if (bus.sample_stb) begin
            unique case (state_q)
                StMuted: begin
                    if (!bus.mute) begin
                        state_q    <= StRampUp;
                        step_cnt_q <= '0;
                        muted_q    <= 1'b0;
                        ramping_q  <= 1'b1;
                    end
                end
                StRampUp: begin
                    if (bus.mute) begin
                        // Reverse direction from the current gain; no jump.
                        state_q    <= StRampDown;
                        step_cnt_q <= '0;
                    end else if (step_done) begin
                        step_cnt_q <= '0;
                        if (gain_q >= GAIN_TOP) begin
                            gain_q    <= GAIN_UNITY;
                            state_q   <= StUnity;
                            ramping_q <= 1'b0;
                        end else begin
                            gain_q <= gain_q + GAIN_ONE;
                        end
                    end else begin
                        step_cnt_q <= step_cnt_q + CNT_ONE;
                    end
                end
                StUnity: begin
                    if (bus.mute) begin
                        state_q    <= StRampDown;
                        step_cnt_q <= '0;
                        ramping_q  <= 1'b1;
                    end
                end
                StRampDown: begin
                    if (!bus.mute) begin
                        state_q    <= StRampUp;
                        step_cnt_q <= '0;
                    end else if (step_done) begin
                        step_cnt_q <= '0;
                        // Clamp at zero so a mute straight after unmute cannot underflow.
                        if (gain_q <= GAIN_ONE) begin
                            gain_q    <= '0;
                            state_q   <= StMuted;
                            muted_q   <= 1'b1;
                            ramping_q <= 1'b0;
                        end else begin
                            gain_q <= gain_q - GAIN_ONE;
                        end
                    end else begin
                        step_cnt_q <= step_cnt_q + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // Stage 0: capture the sample pair with the gain in force before this strobe's update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_valid_q <= 1'b0;
            cap_l_q     <= '0;
            cap_r_q     <= '0;
            cap_gain_q  <= '0;
        end else begin
            cap_valid_q <= bus.sample_stb;
            if (bus.sample_stb) begin
                cap_l_q    <= bus.in_l;
                cap_r_q    <= bus.in_r;
                cap_gain_q <= gain_q;
            end
        end
    end

    // Signed sample times unsigned gain, both extended to the full product width.
    always_comb begin
        gain_ext = {{DATA_W{1'b0}}, cap_gain_q};
        mul_l    = {{(GAIN_W + 1){cap_l_q[DATA_W-1]}}, cap_l_q} * gain_ext;
        mul_r    = {{(GAIN_W + 1){cap_r_q[DATA_W-1]}}, cap_r_q} * gain_ext;
    end

    // Stage 1: register the products; they hold between strobes, so the outputs do too.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_valid_q <= 1'b0;
            prod_l_q     <= '0;
            prod_r_q     <= '0;
        end else begin
            prod_valid_q <= cap_valid_q;
            if (cap_valid_q) begin
                prod_l_q <= mul_l;
                prod_r_q <= mul_r;
            end
        end
    end

    // Stage 2: arithmetic shift by GAIN_W is a bit slice (floor toward -inf).
    // gain <= unity guarantees the slice holds the whole result.
    assign bus.out_l     = prod_l_q[GAIN_W +: DATA_W];
    assign bus.out_r     = prod_r_q[GAIN_W +: DATA_W];
    assign bus.out_valid = prod_valid_q;
    assign bus.muted     = muted_q;
    assign bus.ramping   = ramping_q;

    assign unused_prod_bits = ^{prod_l_q[GAIN_W-1:0], prod_l_q[PROD_W-1],
                                prod_r_q[GAIN_W-1:0], prod_r_q[PROD_W-1]};

endmodule

// File: tb/tb_audio_soft_ramp.sv
// Bench for audio_soft_ramp with GAIN_W=3, STEP_SAMPLES=4.
// A behavioural gain model predicts each scaled pair when the strobe is driven.
// A monitor pops the predictions and compares them with the DUT output and its arrival cycle.
module tb_audio_soft_ramp;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned GAIN_W = 3;
    localparam int unsigned STEP   = 4;
    localparam int          UNITY  = 8;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          due;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   checks  = 0;
    int   passes  = 0;
    exp_t sb[$];

    // Model state: 0 muted, 1 ramp up, 2 unity, 3 ramp down
    int m_state = 0;
    int m_gain  = 0;
    int m_cnt   = 0;

    audio_soft_ramp_if #(.DATA_W(DATA_W)) bus ();

    audio_soft_ramp #(
        .DATA_W      (DATA_W),
        .GAIN_W      (GAIN_W),
        .STEP_SAMPLES(STEP)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] scale(input logic [15:0] s, input int g);
        int p;
        p = int'($signed(s)) * g;
        p = p >>> GAIN_W;
        return p[15:0];
    endfunction

    function automatic void model_reset();
        m_state = 0;
        m_gain  = 0;
        m_cnt   = 0;
    endfunction

    function automatic void model_step(input logic m);
        case (m_state)
            0: if (!m) begin m_state = 1; m_cnt = 0; end
            1: begin
                if (m) begin
                    m_state = 3; m_cnt = 0;
                end else if (m_cnt == STEP - 1) begin
                    m_cnt = 0; m_gain++;
                    if (m_gain >= UNITY) begin m_gain = UNITY; m_state = 2; end
                end else begin
                    m_cnt++;
                end
            end
            2: if (m) begin m_state = 3; m_cnt = 0; end
            default: begin
                if (!m) begin
                    m_state = 1; m_cnt = 0;
                end else if (m_cnt == STEP - 1) begin
                    m_cnt = 0; m_gain--;
                    if (m_gain <= 0) begin m_gain = 0; m_state = 0; end
                end else begin
                    m_cnt++;
                end
            end
        endcase
    endfunction

    // Called at posedge+1; returns one cycle later with the strobe dropped.
    task automatic drive_stb(input logic [15:0] l, input logic [15:0] r, input logic m);
        exp_t e;
        bus.in_l       = l;
        bus.in_r       = r;
        bus.mute       = m;
        bus.sample_stb = 1'b1;
        e.l   = scale(l, m_gain);
        e.r   = scale(r, m_gain);
        e.due = cyc + 2;
        sb.push_back(e);
        model_step(m);
        @(posedge clk);
        #1;
        bus.sample_stb = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_valid: out_valid=1 at cycle %0d, required none", cyc);
                end else begin
                    e = sb.pop_front();
                    if ({bus.out_l, bus.out_r} !== {e.l, e.r} || cyc != e.due)
                        $display("FAIL sample: got l=%h r=%h at cycle %0d, required l=%h r=%h at %0d",
                                 bus.out_l, bus.out_r, cyc, e.l, e.r, e.due);
                    else
                        passes++;
                end
            end else if (sb.size() > 0 && sb[0].due < cyc) begin
                checks++;
                e = sb.pop_front();
                $display("FAIL missing_valid: no out_valid by cycle %0d, required at %0d", cyc, e.due);
            end
        end
    endtask

    task automatic test_reset();
        bus.sample_stb = 1'b0;
        bus.in_l       = 16'h7FFF;
        bus.in_r       = 16'h8001;
        bus.mute       = 1'b0;
        reset_n        = 1'b0;
        model_reset();
        idle(2);
        for (int i = 0; i < 3; i++) begin
            bus.sample_stb = 1'b1;
            idle(1);
            bus.sample_stb = 1'b0;
            idle(1);
            checks++;
            if ({bus.out_l, bus.out_r, bus.out_valid, bus.muted, bus.ramping} !==
                {16'h0, 16'h0, 1'b0, 1'b1, 1'b0})
                $display("FAIL reset_state: l=%h r=%h v=%b muted=%b ramping=%b, required 0 0 0 1 0",
                         bus.out_l, bus.out_r, bus.out_valid, bus.muted, bus.ramping);
            else
                passes++;
        end
        reset_n = 1'b1;
        idle(2);
        checks++;
        if ({bus.out_valid, bus.muted, bus.ramping} !== 3'b010)
            $display("FAIL reset_release: v=%b muted=%b ramping=%b, required 0 1 0",
                     bus.out_valid, bus.muted, bus.ramping);
        else
            passes++;
    endtask

    task automatic test_ramp_up();
        int n;
        drive_stb(16'h4000, 16'hC000, 1'b0);
        n = 1;
        checks++;
        if ({bus.muted, bus.ramping} !== 2'b01)
            $display("FAIL ramp_enter: muted=%b ramping=%b, required 0 1", bus.muted, bus.ramping);
        else
            passes++;
        idle(7);
        while (bus.ramping === 1'b1 && n < 60) begin
            drive_stb(16'h4000, 16'hC000, 1'b0);
            n++;
            idle(7);
        end
        checks++;
        if (n != 33) $display("FAIL ramp_length: %0d strobes to unity, required 33", n);
        else passes++;
        checks++;
        if ({bus.muted, bus.ramping} !== 2'b00)
            $display("FAIL unity_flags: muted=%b ramping=%b, required 0 0", bus.muted, bus.ramping);
        else
            passes++;
        drive_stb(16'h4000, 16'hC000, 1'b0);
        idle(1);
        checks++;
        if ({bus.out_l, bus.out_r} !== {16'h4000, 16'hC000})
            $display("FAIL unity_exact: l=%h r=%h, required 4000 c000", bus.out_l, bus.out_r);
        else
            passes++;
        idle(4);
    endtask

    task automatic test_rounding();
        drive_stb(16'hFFFF, 16'h8000, 1'b0);
        idle(1);
        checks++;
        if ({bus.out_l, bus.out_r} !== {16'hFFFF, 16'h8000})
            $display("FAIL unity_min: l=%h r=%h, required ffff 8000", bus.out_l, bus.out_r);
        else
            passes++;
        idle(2);
        // Ramp down from unity to gain 4, then unmute to hold there
        for (int i = 0; i < 17; i++) drive_stb(16'h1000, 16'hF000, 1'b1);
        drive_stb(16'h1000, 16'hF000, 1'b0);
        idle(2);
        drive_stb(16'hFFFF, 16'h0003, 1'b0);
        idle(1);
        checks++;
        if ({bus.out_l, bus.out_r} !== {16'hFFFF, 16'h0001})
            $display("FAIL floor_gain4: l=%h r=%h, required ffff 0001", bus.out_l, bus.out_r);
        else
            passes++;
        drive_stb(16'h0003, 16'hFFFF, 1'b0);
        idle(1);
        checks++;
        if ({bus.out_l, bus.out_r} !== {16'h0001, 16'hFFFF})
            $display("FAIL floor_gain4_swap: l=%h r=%h, required 0001 ffff", bus.out_l, bus.out_r);
        else
            passes++;
        idle(2);
    endtask

    task automatic test_mute_mid_ramp();
        int n;
        int guard;
        guard = 0;
        while (m_gain != 5 && guard < 10) begin
            drive_stb(16'h2000, 16'hE000, 1'b0);
            guard++;
        end
        drive_stb(16'h2000, 16'hE000, 1'b1);
        checks++;
        if ({bus.muted, bus.ramping} !== 2'b01)
            $display("FAIL mute_turn: muted=%b ramping=%b, required 0 1", bus.muted, bus.ramping);
        else
            passes++;
        idle(1);
        checks++;
        if (bus.out_l !== 16'h1400)
            $display("FAIL no_jump: l=%h, required 1400", bus.out_l);
        else
            passes++;
        n = 0;
        while (bus.muted !== 1'b1 && n < 40) begin
            drive_stb(16'h2000, 16'hE000, 1'b1);
            n++;
        end
        checks++;
        if (n != 20) $display("FAIL ramp_down_length: %0d strobes to muted, required 20", n);
        else passes++;
        idle(2);
        drive_stb(16'h7FFF, 16'h8000, 1'b1);
        idle(1);
        checks++;
        if ({bus.out_l, bus.out_r, bus.muted, bus.ramping} !== {16'h0, 16'h0, 1'b1, 1'b0})
            $display("FAIL muted_silence: l=%h r=%h muted=%b ramping=%b, required 0 0 1 0",
                     bus.out_l, bus.out_r, bus.muted, bus.ramping);
        else
            passes++;
        idle(2);
    endtask

    task automatic test_reset_mid_pipeline();
        for (int i = 0; i < 7; i++) drive_stb(16'h4000, 16'h4000, 1'b0);
        idle(3);
        checks++;
        if (bus.out_l !== 16'h0800)
            $display("FAIL pre_reset_level: l=%h, required 0800", bus.out_l);
        else
            passes++;
        drive_stb(16'h1234, 16'h5678, 1'b0);
        sb.delete();
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bus.out_l, bus.out_r, bus.out_valid, bus.muted, bus.ramping} !==
            {16'h0, 16'h0, 1'b0, 1'b1, 1'b0})
            $display("FAIL reset_flush: l=%h r=%h v=%b muted=%b ramping=%b, required 0 0 0 1 0",
                     bus.out_l, bus.out_r, bus.out_valid, bus.muted, bus.ramping);
        else
            passes++;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            checks++;
            if ({bus.out_l, bus.out_valid} !== {16'h0, 1'b0})
                $display("FAIL reset_hold: l=%h v=%b, required 0 0", bus.out_l, bus.out_valid);
            else
                passes++;
        end
        reset_n = 1'b1;
        idle(2);
        drive_stb(16'h4000, 16'h4000, 1'b0);
        checks++;
        if ({bus.muted, bus.ramping} !== 2'b01)
            $display("FAIL restart: muted=%b ramping=%b, required 0 1", bus.muted, bus.ramping);
        else
            passes++;
        idle(3);
    endtask

    task automatic test_back_to_back();
        int guard;
        guard = 0;
        while (m_state != 2 && guard < 60) begin
            drive_stb(16'h0100, 16'hFF00, 1'b0);
            guard++;
        end
        idle(3);
        for (int i = 0; i < 10; i++) drive_stb(16'($urandom), 16'($urandom), 1'b0);
        idle(4);
        checks++;
        if (sb.size() != 0) $display("FAIL burst_drain: %0d pending, required 0", sb.size());
        else passes++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", passes, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sample_stb = 1'b0;
        bus.in_l       = '0;
        bus.in_r       = '0;
        bus.mute       = 1'b1;
        fork
            monitor();
        join_none
        #1;
        test_reset();
        test_ramp_up();
        test_rounding();
        test_mute_mid_ramp();
        test_reset_mid_pipeline();
        test_back_to_back();
        idle(6);
        checks++;
        if (sb.size() != 0) $display("FAIL final_drain: %0d pending, required 0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
